// File: rtl/block_memory_core_v2.sv
// Dual-port block memory on the daisy-chained 16-bit register bus.
// Wide words are split into 16-bit chunks mapped chunk-major above BASE_ADDR.
// Bus writes stage the lower chunks and commit the whole word on the top chunk.
// A chunk-0 bus read snapshots the whole word so later chunk reads are coherent.
module block_memory_core_v2 #(
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256,
  parameter int WIDTH     = 33,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           addr_i,
  input  logic [15:0]           wdata_i,
  input  logic [15:0]           rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [15:0]           addr_o,
  output logic [15:0]           wdata_o,
  output logic [15:0]           rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] user_addr,
  input  logic [WIDTH-1:0]      user_din,
  output logic [WIDTH-1:0]      user_dout,
  input  logic                  user_we
);

  localparam int N_CHUNKS = (WIDTH + 15) / 16;
  localparam int MAX_ADDR = BASE_ADDR + N_CHUNKS * DEPTH - 1;
  localparam int CHUNK_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam int STG_N    = (N_CHUNKS > 1) ? N_CHUNKS - 1 : 1;
  localparam int SNAP_W   = 16 * N_CHUNKS;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [31:0]           offset;
  logic                  in_match;
  logic [ADDR_WIDTH-1:0] in_word;
  logic [CHUNK_W-1:0]    in_chunk;

  logic                  s1_valid;
  logic                  s1_rw;
  logic                  s1_match;
  logic [15:0]           s1_addr;
  logic [15:0]           s1_wdata;
  logic [15:0]           s1_rdata;
  logic [ADDR_WIDTH-1:0] s1_word;
  logic [CHUNK_W-1:0]    s1_chunk;

  logic [ADDR_WIDTH-1:0] u_addr_q;
  logic [WIDTH-1:0]      u_din_q;
  logic                  u_we_q;

  logic [STG_N-1:0][15:0]    staging;
  logic [N_CHUNKS-1:0][15:0] snapshot;

  logic              is_top;
  logic              bus_commit;
  logic              stage_wr;
  logic              snap_rd;
  logic              commit_lost;
  logic [WIDTH-1:0]  commit_word;
  logic [SNAP_W-1:0] bus_word;
  logic [15:0]       snap_sel;

  // Decode the incoming bus address into match flag, word index and chunk index
  always_comb begin
    offset   = 32'(addr_i) - 32'(BASE_ADDR);
    in_match = (32'(addr_i) >= 32'(BASE_ADDR)) && (32'(addr_i) <= 32'(MAX_ADDR));
    in_word  = offset[ADDR_WIDTH-1:0];
    in_chunk = CHUNK_W'(offset >> ADDR_WIDTH);
  end

  // First pipeline stage: capture the transaction; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_i;
    end
    if (valid_i) begin
      s1_rw    <= rw_i;
      s1_match <= in_match;
      s1_addr  <= addr_i;
      s1_wdata <= wdata_i;
      s1_rdata <= rdata_i;
      s1_word  <= in_word;
      s1_chunk <= in_chunk;
    end
  end

  // User side address/data/enable register ahead of the memory
  always_ff @(posedge clk) begin
    u_addr_q <= user_addr;
    u_din_q  <= user_din;
    u_we_q   <= user_we;
  end

  // Classify the staged transaction; a same-word user write beats a bus commit
  always_comb begin
    is_top      = (s1_chunk == CHUNK_W'(N_CHUNKS - 1));
    bus_commit  = s1_valid && s1_match && s1_rw && is_top && !rst;
    stage_wr    = s1_valid && s1_match && s1_rw && !is_top;
    snap_rd     = s1_valid && s1_match && !s1_rw && (s1_chunk == '0);
    commit_lost = u_we_q && (u_addr_q == s1_word);
    bus_word    = SNAP_W'(mem[s1_word]);
    snap_sel    = '0;
    for (int c = 0; c < N_CHUNKS; c++) begin
      if (s1_chunk == CHUNK_W'(c)) begin
        snap_sel = snapshot[c];
      end
    end
  end

  // Commit word: low bits of the top chunk above the staged lower chunks
  generate
    if (N_CHUNKS > 1) begin : g_multi
      assign commit_word = {s1_wdata[WIDTH-16*(N_CHUNKS-1)-1:0], staging};
    end else begin : g_single
      assign commit_word = s1_wdata[WIDTH-1:0];
    end
  endgenerate

  // Memory array writes; the user write is issued last so it wins on a shared word
  always_ff @(posedge clk) begin
    if (bus_commit && !commit_lost) begin
      mem[s1_word] <= commit_word;
    end
    if (u_we_q) begin
      mem[u_addr_q] <= u_din_q;
    end
  end

  // Staging of lower write chunks and snapshot of whole words on chunk-0 reads
  always_ff @(posedge clk) begin
    if (rst) begin
      staging  <= '0;
      snapshot <= '0;
    end else begin
      if (stage_wr) begin
        for (int c = 0; c < STG_N; c++) begin
          if (s1_chunk == CHUNK_W'(c)) begin
            staging[c] <= s1_wdata;
          end
        end
      end
      if (snap_rd) begin
        snapshot <= bus_word;
      end
    end
  end

  // User read output register, read-first against a same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      user_dout <= '0;
    end else begin
      user_dout <= mem[u_addr_q];
    end
  end

  // Second pipeline stage: drive the bus outputs, holding them between transactions
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
      rdata_o <= '0;
      rw_o    <= 1'b0;
    end else begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        addr_o  <= s1_addr;
        wdata_o <= s1_wdata;
        rw_o    <= s1_rw;
        if (!s1_match || s1_rw) begin
          rdata_o <= s1_rdata;
        end else if (s1_chunk == '0) begin
          rdata_o <= bus_word[15:0];
        end else begin
          rdata_o <= snap_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_memory_core_v2.sv
// Self-checking bench for block_memory_core_v2 (BASE_ADDR=0, DEPTH=256, WIDTH=33).
// A word-level model predicts every bus/user output two cycles after the inputs.
module tb_block_memory_core_v2;

  localparam int BASE  = 0;
  localparam int DEPTH = 256;
  localparam int WIDTH = 33;
  localparam int NCH   = 3;
  localparam int AW    = 8;
  localparam int NEXP  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       addr_i, wdata_i, rdata_i;
  logic              rw_i, valid_i;
  logic [15:0]       addr_o, wdata_o, rdata_o;
  logic              rw_o, valid_o;
  logic [AW-1:0]     user_addr;
  logic [WIDTH-1:0]  user_din, user_dout;
  logic              user_we;

  typedef struct {
    bit          chk_valid;
    bit          valid;
    bit          chk_bus;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rw;
    bit          chk_rdata;
    logic [15:0] rdata;
    bit          chk_dout;
    logic [32:0] dout;
  } exp_t;

  exp_t        exp_q [NEXP];
  logic [32:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_stg [2];
  logic [15:0] m_snap [3];
  bit          m_snap_known = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;
  int pcount = 0;

  block_memory_core_v2 #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .user_addr(user_addr), .user_din(user_din), .user_dout(user_dout), .user_we(user_we)
  );

  // Free-running clock and an edge counter used to time expectations
  always #5 clk = ~clk;

  always @(posedge clk) pcount++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, want, pcount);
    end
  endtask

  // Drive one cycle of inputs and advance the word-level model by that cycle
  task automatic applyStimulus(input bit v, input bit wr, input logic [15:0] a,
                               input logic [15:0] wd, input logic [15:0] rd,
                               input bit uwe, input logic [7:0] ua,
                               input logic [32:0] ud, input bit r);
    exp_t e;
    exp_t z;
    int k, ai, off, word, chunk;
    logic [47:0] full;
    @(posedge clk);
    #1;
    k = pcount;
    valid_i = v; rw_i = wr; addr_i = a; wdata_i = wd; rdata_i = rd;
    user_we = uwe; user_addr = ua; user_din = ud; rst = r;
    e = '{default: '0};
    e.chk_valid = 1'b1;
    e.valid = v && !r;
    if (m_known[ua]) begin
      e.chk_dout = 1'b1;
      e.dout = m_mem[ua];
    end
    if (v && !r) begin
      e.chk_bus = 1'b1; e.addr = a; e.wdata = wd; e.rw = wr;
      e.chk_rdata = 1'b1; e.rdata = rd;
      ai = int'(a);
      if (ai >= BASE && ai < BASE + NCH * DEPTH) begin
        off = ai - BASE;
        word = off % DEPTH;
        chunk = off / DEPTH;
        if (wr) begin
          if (chunk < NCH - 1) begin
            m_stg[chunk] = wd;
          end else begin
            full = {wd, m_stg[1], m_stg[0]};
            m_mem[word] = full[WIDTH-1:0];
            m_known[word] = 1'b1;
          end
        end else if (chunk == 0) begin
          e.chk_rdata = m_known[word];
          e.rdata = m_mem[word][15:0];
          m_snap_known = m_known[word];
          full = 48'(m_mem[word]);
          m_snap[0] = full[15:0];
          m_snap[1] = full[31:16];
          m_snap[2] = full[47:32];
        end else begin
          e.chk_rdata = m_snap_known;
          e.rdata = m_snap[chunk];
        end
      end
    end
    if (uwe) begin
      m_mem[ua] = ud;
      m_known[ua] = 1'b1;
    end
    if (r) begin
      m_stg[0] = '0; m_stg[1] = '0;
      m_snap[0] = '0; m_snap[1] = '0; m_snap[2] = '0;
      m_snap_known = 1'b1;
      z = '{default: '0};
      z.chk_valid = 1'b1; z.chk_bus = 1'b1; z.chk_rdata = 1'b1; z.chk_dout = 1'b1;
      exp_q[k+1] = z;
    end
    exp_q[k+2] = e;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 8'h0, 33'h0, 0);
  endtask

  task automatic settle();
    idle();
    idle();
    @(negedge clk);
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [15:0] wd);
    applyStimulus(1, 1, a, wd, 16'h0, 0, 8'h0, 33'h0, 0);
  endtask

  task automatic busRead(input logic [15:0] a, input logic [15:0] rd);
    applyStimulus(1, 0, a, 16'h0, rd, 0, 8'h0, 33'h0, 0);
  endtask

  task automatic userWrite(input logic [7:0] ua, input logic [32:0] ud);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 1, ua, ud, 0);
  endtask

  task automatic userRead(input logic [7:0] ua);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, ua, 33'h0, 0);
  endtask

  // Compare every cycle's outputs against the model prediction for that edge
  always @(negedge clk) begin : compare
    exp_t e;
    if (pcount < NEXP) begin
      e = exp_q[pcount];
      if (e.chk_valid) checkOutput("valid_o", 64'(valid_o), 64'(e.valid));
      if (e.chk_bus) begin
        checkOutput("addr_o", 64'(addr_o), 64'(e.addr));
        checkOutput("wdata_o", 64'(wdata_o), 64'(e.wdata));
        checkOutput("rw_o", 64'(rw_o), 64'(e.rw));
      end
      if (e.chk_rdata) checkOutput("rdata_o", 64'(rdata_o), 64'(e.rdata));
      if (e.chk_dout) checkOutput("user_dout", 64'(user_dout), 64'(e.dout));
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic
  initial begin
    logic [63:0] rnd;
    int sel;
    logic [15:0] ra;
    m_stg[0] = '0; m_stg[1] = '0;
    m_snap[0] = '0; m_snap[1] = '0; m_snap[2] = '0;

    repeat (3) applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 8'h0, 33'h0, 1);
    idle();
    @(negedge clk);
    checkOutput("reset valid_o", 64'(valid_o), 64'h0);
    checkOutput("reset rdata_o", 64'(rdata_o), 64'h0);
    checkOutput("reset addr_o", 64'(addr_o), 64'h0);
    checkOutput("reset user_dout", 64'(user_dout), 64'h0);

    busWrite(16'd3, 16'h1234);
    busWrite(16'd259, 16'h5678);
    busWrite(16'd515, 16'h0001);
    userRead(8'd3);
    settle();
    checkOutput("commit dout", 64'(user_dout), 64'h1_5678_1234);

    busWrite(16'd3, 16'hAAAA);
    userRead(8'd3);
    settle();
    checkOutput("tearfree hold", 64'(user_dout), 64'h1_5678_1234);
    busWrite(16'd515, 16'hFFFF);
    userRead(8'd3);
    settle();
    checkOutput("tearfree commit", 64'(user_dout), 64'h1_5678_AAAA);

    userWrite(8'd7, 33'h0_DEAD_BEEF);
    busRead(16'd7, 16'h0);
    settle();
    checkOutput("snap chunk0", 64'(rdata_o), 64'hBEEF);
    busRead(16'd263, 16'h0);
    settle();
    checkOutput("snap chunk1", 64'(rdata_o), 64'hDEAD);
    busRead(16'd519, 16'h0);
    settle();
    checkOutput("snap chunk2", 64'(rdata_o), 64'h0000);
    userWrite(8'd7, 33'h1_FFFF_FFFF);
    busRead(16'd263, 16'h0);
    settle();
    checkOutput("snap stale", 64'(rdata_o), 64'hDEAD);

    busRead(16'd768, 16'h4242);
    settle();
    checkOutput("pass valid_o", 64'(valid_o), 64'h1);
    checkOutput("pass addr_o", 64'(addr_o), 64'd768);
    checkOutput("pass rdata_o", 64'(rdata_o), 64'h4242);
    userRead(8'd3);
    settle();
    checkOutput("pass untouched", 64'(user_dout), 64'h1_5678_AAAA);

    busRead(16'd3, 16'h0);
    busRead(16'd768, 16'h4242);
    idle();
    @(negedge clk);
    checkOutput("b2b first valid", 64'(valid_o), 64'h1);
    checkOutput("b2b first addr", 64'(addr_o), 64'd3);
    checkOutput("b2b first rdata", 64'(rdata_o), 64'hAAAA);
    idle();
    @(negedge clk);
    checkOutput("b2b second valid", 64'(valid_o), 64'h1);
    checkOutput("b2b second addr", 64'(addr_o), 64'd768);

    busWrite(16'd2, 16'h1111);
    busWrite(16'd258, 16'h2222);
    applyStimulus(1, 1, 16'd514, 16'h0000, 16'h0, 1, 8'd2, 33'h0_3333_4444, 0);
    userRead(8'd2);
    settle();
    checkOutput("collision dout", 64'(user_dout), 64'h0_3333_4444);

    busRead(16'd3, 16'h0);
    applyStimulus(0, 0, 16'h0, 16'h0, 16'h0, 0, 8'h0, 33'h0, 1);
    idle();
    @(negedge clk);
    checkOutput("midreset valid_o", 64'(valid_o), 64'h0);
    checkOutput("midreset addr_o", 64'(addr_o), 64'h0);
    checkOutput("midreset rdata_o", 64'(rdata_o), 64'h0);
    checkOutput("midreset user_dout", 64'(user_dout), 64'h0);
    busRead(16'd256, 16'h0);
    settle();
    checkOutput("post-reset valid", 64'(valid_o), 64'h1);
    checkOutput("post-reset snap", 64'(rdata_o), 64'h0000);

    for (int i = 0; i < 800; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6) begin
        ra = 16'((sel <= 2 ? 0 : (sel <= 4 ? 1 : 2)) * DEPTH + $urandom_range(0, 7));
      end else if (sel <= 8) begin
        ra = 16'(768 + $urandom_range(0, 2000));
      end else begin
        ra = 16'(16'hFFFF - $urandom_range(0, 15));
      end
      rnd = {$urandom(), $urandom()};
      applyStimulus(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, ra,
                    16'($urandom()), 16'($urandom()), ($urandom_range(0, 3) == 0),
                    8'($urandom_range(0, 7)), rnd[32:0], 0);
    end
    repeat (3) idle();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
